lpc_residual_decoder: RTL and testbench
=======================================

// Module: lpc_residual_decoder
// PURPOSE
//  Decode-side inverse of the Stage 3 encoder (LPC residual synthesis filter).
//  Loads up to MAX_ORDER quantised LPC coefficients, passes M warm-up samples verbatim,
//  then rebuilds each sample as residual + (sum qlp[j]*s[n-1-j]) >>> shift.
//  Sits between the Rice decoder (residual source) and the PCM output stage.
//  Uses one serial MAC, one tap per cycle; each frame is BLOCK_SIZE samples.
// PARAMETERS
//  MAX_ORDER   12    maximum predictor order (history and coefficient depth)
//  DATA_W      16    sample/residual width (signed)
//  COEFF_W     12    quantised coefficient width (signed)
//  ACC_W       40    accumulator width (signed)
//  BLOCK_SIZE  4096  output samples per frame
// PORTS
//  iClock      in   1        clock, all logic on rising edge
//  iReset      in   1        synchronous, active-high reset
//  iEnable     in   1        clock enable; low = freeze all state
//  iLoad       in   1        coefficient load strobe, one coefficient per cycle
//  iM          in   4        predictor order 0..MAX_ORDER, latched on first iLoad cycle
//  iShift      in   5        quantisation shift 0..15, latched on first iLoad cycle
//  iCoeff      in   COEFF_W  signed coefficient, qlp[0] first (qlp[0] multiplies s[n-1])
//  iValid      in   1        input word valid: warm-up sample or residual
//  iResidual   in   DATA_W   signed warm-up sample / residual
//  oReady      out  1        block accepts iResidual this cycle
//  oSample     out  DATA_W   signed reconstructed sample
//  oValid      out  1        oSample valid, 1-cycle pulse
//  oFrameDone  out  1        1-cycle pulse with the BLOCK_SIZE-th oValid
// BEHAVIOUR
//  Reset: state=IDLE; oSample=0; oValid=0; oReady=0; oFrameDone=0;
//   coefficients, history, accumulator, load and frame counters cleared.
//   Reset mid-operation abandons the frame; block is back in IDLE on the next cycle.
//  iEnable low: no register changes; oReady, oValid, oFrameDone gated to 0.
//   A pending output is presented when iEnable returns high.
//  Transfer: occurs when iValid & oReady & iEnable. iValid while oReady=0 is ignored.
//  IDLE: oReady=0. First iLoad cycle latches iM and iShift and stores iCoeff as qlp[0].
//   If iM=0, go directly to RUN. If iM=1, go to WARMUP. Otherwise go to LOAD.
//  LOAD: each iLoad cycle stores the next qlp[k]. After M coefficients, go to WARMUP.
//   iLoad low pauses loading. iLoad outside IDLE/LOAD is ignored.
//  WARMUP: oReady=1. Each accepted word is pushed into history (s[n-1] at index 0).
//   It appears on oSample with oValid 1 cycle later.
//   After M warm-up words, go to RUN; still no gap, one word per cycle.
//  RUN: oReady=1 in the WAIT substate. Accept at cycle t sets oReady=0.
//   Cycles t+1..t+M: acc += qlp[j]*hist[j], j=0..M-1.
//   Each product is a full DATA_W+COEFF_W signed product, sign-extended to ACC_W.
//   Cycle t+M+1: sample = residual + (acc >>> iShift), arithmetic shift.
//   The result is truncated (wrap-around) to DATA_W. oValid=1, oSample registered.
//   The sample is pushed into history, acc is cleared and oReady=1 again
//   (next accept may occur in this same cycle).
//   Latency is M+1 cycles (M=0: 1 cycle, back-to-back).
//  Frame: output counter increments on every oValid (warm-up included).
//   On the BLOCK_SIZE-th output, oFrameDone=1 with that oValid.
//   State then returns to IDLE, counters and history clear and oReady=0.
//   A new frame requires a fresh coefficient load.
//  Simultaneous iLoad and iValid in LOAD: the load proceeds and iValid is ignored (oReady=0).
//  iM > MAX_ORDER is clamped to MAX_ORDER.
// TESTING
//  1 M=1, qlp={1}, sh=0; warm-up 100, residuals 5,5,5 -> oSample 100,105,110,115.
//    Warm-up latency 1 cycle; run latency 2 cycles.
//  2 M=2, qlp={2,-1}, sh=0; warm-up 10,20, residuals 0,0,0 -> 10,20,30,40,50.
//    oReady low exactly 2 cycles after each residual.
//  3 M=1, qlp={3}, sh=1; warm-up -3, residual 0 -> pred = -9>>>1 = -5, oSample -5.
//  4 M=1, qlp={1}, sh=0; warm-up 32767, residual 1 -> oSample -32768 (wrap).
//  5 BLOCK_SIZE=8, M=0; 8 residuals back-to-back -> 8 outputs equal to inputs.
//    oFrameDone with the 8th oValid; next cycle oReady=0, IDLE.
//  6 M=12, reset asserted during MAC cycle 5 -> next cycle oValid=0, oReady=0.
//    A subsequent reload and frame decodes correctly; iEnable low mid-MAC stretches latency 1:1.

Source files
------------

// File: rtl/lpc_residual_decoder.sv
// lpc_residual_decoder: LPC synthesis filter, decode-side inverse of the residual encoder.
//   Loads up to MAX_ORDER quantised coefficients, passes M warm-up samples verbatim,
//   then rebuilds each sample as residual + (sum qlp[j]*s[n-1-j]) >>> shift with one serial MAC.
// Ports: iClock/iReset (sync, active-high), iEnable (freeze when low),
//   iLoad/iM/iShift/iCoeff (coefficient load), iValid/iResidual/oReady (input handshake),
//   oSample/oValid (reconstructed sample pulse), oFrameDone (last sample of a frame).
module lpc_residual_decoder #(
  parameter int MAX_ORDER  = 12,
  parameter int DATA_W     = 16,
  parameter int COEFF_W    = 12,
  parameter int ACC_W      = 40,
  parameter int BLOCK_SIZE = 4096
) (
  input  logic                      iClock,
  input  logic                      iReset,
  input  logic                      iEnable,
  input  logic                      iLoad,
  input  logic [3:0]                iM,
  input  logic [4:0]                iShift,
  input  logic signed [COEFF_W-1:0] iCoeff,
  input  logic                      iValid,
  input  logic signed [DATA_W-1:0]  iResidual,
  output logic                      oReady,
  output logic signed [DATA_W-1:0]  oSample,
  output logic                      oValid,
  output logic                      oFrameDone
);

  localparam int TAP_W  = $clog2(MAX_ORDER + 1);
  localparam int CNT_W  = $clog2(BLOCK_SIZE);
  localparam int PROD_W = DATA_W + COEFF_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WARMUP,
    S_WAIT,
    S_MAC
  } state_t;

  state_t                     state_q;
  logic [TAP_W-1:0]           m_q;
  logic [4:0]                 shift_q;
  logic [TAP_W-1:0]           lcnt_q;
  logic [TAP_W-1:0]           wcnt_q;
  logic [TAP_W-1:0]           tap_q;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [DATA_W-1:0]   res_q;
  logic [CNT_W-1:0]           out_cnt_q;
  logic signed [DATA_W-1:0]   sample_q;
  logic                       valid_q;
  logic                       done_q;
  logic signed [COEFF_W-1:0]  coeff_q [MAX_ORDER];
  // hist_q[0] is the most recent sample s[n-1]
  logic signed [DATA_W-1:0]   hist_q  [MAX_ORDER];

  logic                       accept;
  logic [TAP_W-1:0]           m_clamp;
  logic signed [PROD_W-1:0]   prod_d;
  logic signed [ACC_W-1:0]    acc_d;
  logic signed [DATA_W-1:0]   sample_d;
  logic                       last_tap;
  logic                       out_fire;
  logic signed [DATA_W-1:0]   out_data;
  logic                       frame_last;

  assign oReady     = iEnable & ((state_q == S_WARMUP) | (state_q == S_WAIT));
  assign oValid     = iEnable & valid_q;
  assign oFrameDone = iEnable & done_q;
  assign oSample    = sample_q;
  assign accept     = iValid & oReady;

  always_comb begin
    m_clamp    = (int'(iM) > MAX_ORDER) ? TAP_W'(MAX_ORDER) : TAP_W'(iM);
    prod_d     = PROD_W'(coeff_q[tap_q]) * PROD_W'(hist_q[tap_q]);
    acc_d      = acc_q + ACC_W'(prod_d);
    // Final tap is folded in combinationally so the result registers on the last MAC edge.
    sample_d   = DATA_W'((acc_d >>> shift_q) + ACC_W'(res_q));
    last_tap   = (tap_q == m_q - TAP_W'(1));
    out_fire   = ((state_q == S_WARMUP) & accept) |
                 ((state_q == S_WAIT) & accept & (m_q == '0)) |
                 ((state_q == S_MAC) & last_tap);
    out_data   = (state_q == S_MAC) ? sample_d : iResidual;
    frame_last = out_fire & (out_cnt_q == CNT_W'(BLOCK_SIZE - 1));
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q   <= S_IDLE;
      m_q       <= '0;
      shift_q   <= '0;
      lcnt_q    <= '0;
      wcnt_q    <= '0;
      tap_q     <= '0;
      acc_q     <= '0;
      res_q     <= '0;
      out_cnt_q <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < MAX_ORDER; i++) begin
        coeff_q[i] <= '0;
        hist_q[i]  <= '0;
      end
    end else if (iEnable) begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (iLoad) begin
            m_q        <= m_clamp;
            shift_q    <= iShift;
            coeff_q[0] <= iCoeff;
            lcnt_q     <= TAP_W'(1);
            wcnt_q     <= '0;
            if (m_clamp == '0)             state_q <= S_WAIT;
            else if (m_clamp == TAP_W'(1)) state_q <= S_WARMUP;
            else                           state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (iLoad) begin
            coeff_q[lcnt_q] <= iCoeff;
            lcnt_q          <= lcnt_q + TAP_W'(1);
            if (lcnt_q == m_q - TAP_W'(1)) state_q <= S_WARMUP;
          end
        end
        S_WARMUP: begin
          if (accept) begin
            wcnt_q <= wcnt_q + TAP_W'(1);
            if (wcnt_q == m_q - TAP_W'(1)) state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (accept) begin
            res_q <= iResidual;
            acc_q <= '0;
            tap_q <= '0;
            if (m_q != '0) state_q <= S_MAC;
          end
        end
        S_MAC: begin
          acc_q <= acc_d;
          tap_q <= tap_q + TAP_W'(1);
          if (last_tap) begin
            acc_q   <= '0;
            state_q <= S_WAIT;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (out_fire) begin
        sample_q  <= out_data;
        valid_q   <= 1'b1;
        out_cnt_q <= out_cnt_q + CNT_W'(1);
        hist_q[0] <= out_data;
        for (int i = 1; i < MAX_ORDER; i++) hist_q[i] <= hist_q[i-1];
      end

      // End of frame overrides the normal next state: a fresh load is required.
      if (frame_last) begin
        done_q    <= 1'b1;
        state_q   <= S_IDLE;
        out_cnt_q <= '0;
        lcnt_q    <= '0;
        wcnt_q    <= '0;
        tap_q     <= '0;
        acc_q     <= '0;
        for (int i = 0; i < MAX_ORDER; i++) hist_q[i] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lpc_residual_decoder.sv
module tb_lpc_residual_decoder;

  logic               iClock;
  logic               iReset;
  logic               iEnable;
  logic               iLoad;
  logic [3:0]         iM;
  logic [4:0]         iShift;
  logic signed [11:0] iCoeff;
  logic               iValid;
  logic signed [15:0] iResidual;

  logic               oReady, oValid, oFrameDone;
  logic signed [15:0] oSample;
  logic               o8_ready, o8_valid, o8_done;
  logic signed [15:0] o8_sample;

  int checks = 0;
  int errors = 0;

  lpc_residual_decoder dut (
    .iClock(iClock), .iReset(iReset), .iEnable(iEnable), .iLoad(iLoad),
    .iM(iM), .iShift(iShift), .iCoeff(iCoeff), .iValid(iValid),
    .iResidual(iResidual), .oReady(oReady), .oSample(oSample),
    .oValid(oValid), .oFrameDone(oFrameDone)
  );

  lpc_residual_decoder #(.BLOCK_SIZE(8)) dut8 (
    .iClock(iClock), .iReset(iReset), .iEnable(iEnable), .iLoad(iLoad),
    .iM(iM), .iShift(iShift), .iCoeff(iCoeff), .iValid(iValid),
    .iResidual(iResidual), .oReady(o8_ready), .oSample(o8_sample),
    .oValid(o8_valid), .oFrameDone(o8_done)
  );

  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

  task automatic step();
    @(posedge iClock);
    #1;
  endtask

  task automatic do_reset();
    iReset = 1'b1; iValid = 1'b0; iLoad = 1'b0; iEnable = 1'b1;
    step();
    step();
    iReset = 1'b0;
  endtask

  // Drives mport on iM, then ncoef coefficients on consecutive iLoad cycles.
  task automatic load(input int mport, input int ncoef, input int sh, input int c[12]);
    iLoad = 1'b1; iM = 4'(mport); iShift = 5'(sh); iCoeff = 12'(c[0]);
    step();
    for (int k = 1; k < ncoef; k++) begin
      iCoeff = 12'(c[k]);
      step();
    end
    iLoad = 1'b0;
    iValid = 1'b0;
  endtask

  // Offers one word, then waits (bounded) for the next oValid.
  // lat = cycles from the accepting edge to the output cycle (-1 on timeout);
  // rdy_low = cycles in between where oReady was low.
  task automatic push(input int val, output logic signed [15:0] got,
                      output int lat, output int rdy_low);
    int k;
    k = 0;
    while (!oReady && k < 50) begin step(); k++; end
    iValid = 1'b1; iResidual = 16'(val);
    step();
    iValid = 1'b0;
    lat = 1; rdy_low = 0;
    while (!oValid && lat < 50) begin
      if (!oReady) rdy_low++;
      step();
      lat++;
    end
    if (oValid) got = oSample;
    else begin got = 'x; lat = -1; end
  endtask

  task automatic test_reset();
    iReset = 1'b1; iEnable = 1'b1; iLoad = 1'b0; iValid = 1'b1;
    iM = '0; iShift = '0; iCoeff = '0; iResidual = 16'sd77;
    step();
    step();
    checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", oValid); end
    checks++; if (oReady !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", oReady); end
    checks++; if (oFrameDone !== 1'b0) begin errors++; $display("FAIL reset_framedone: got %b expected 0", oFrameDone); end
    checks++; if (oSample !== 16'sd0) begin errors++; $display("FAIL reset_sample: got %0d expected 0", oSample); end
    iReset = 1'b0;
    step();
    checks++; if (oReady !== 1'b0 || oValid !== 1'b0) begin errors++; $display("FAIL idle_after_reset: ready %b valid %b expected 0 0", oReady, oValid); end
    iValid = 1'b0;
  endtask

  task automatic test_order1();
    int cf[12];
    int vals[4] = '{100, 5, 5, 5};
    int expv[4] = '{100, 105, 110, 115};
    int expl[4] = '{1, 2, 2, 2};
    logic signed [15:0] got;
    int lat, rl;
    do_reset();
    cf = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    load(1, 1, 0, cf);
    checks++; if (oReady !== 1'b1) begin errors++; $display("FAIL order1_warmup_ready: got %b expected 1", oReady); end
    for (int i = 0; i < 4; i++) begin
      push(vals[i], got, lat, rl);
      checks++; if (got !== 16'(expv[i])) begin errors++; $display("FAIL order1_sample[%0d]: got %0d expected %0d", i, got, expv[i]); end
      checks++; if (lat !== expl[i]) begin errors++; $display("FAIL order1_latency[%0d]: got %0d expected %0d", i, lat, expl[i]); end
    end
  endtask

  task automatic test_order2();
    int cf[12];
    int vals[5] = '{10, 20, 0, 0, 0};
    int expv[5] = '{10, 20, 30, 40, 50};
    int expl[5] = '{1, 1, 3, 3, 3};
    logic signed [15:0] got;
    int lat, rl;
    do_reset();
    cf = '{2, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    // A word offered during loading must not be taken.
    iValid = 1'b1; iResidual = 16'sd999;
    load(2, 2, 0, cf);
    for (int i = 0; i < 5; i++) begin
      push(vals[i], got, lat, rl);
      checks++; if (got !== 16'(expv[i])) begin errors++; $display("FAIL order2_sample[%0d]: got %0d expected %0d", i, got, expv[i]); end
      checks++; if (lat !== expl[i]) begin errors++; $display("FAIL order2_latency[%0d]: got %0d expected %0d", i, lat, expl[i]); end
      if (i >= 2) begin
        checks++; if (rl !== 2) begin errors++; $display("FAIL order2_ready_low[%0d]: got %0d cycles expected 2", i, rl); end
        checks++; if (oReady !== 1'b1) begin errors++; $display("FAIL order2_ready_at_out[%0d]: got %b expected 1", i, oReady); end
      end
    end
  endtask

  task automatic test_shift_and_wrap();
    int cf[12];
    logic signed [15:0] got;
    int lat, rl;
    do_reset();
    cf = '{3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    load(1, 1, 1, cf);
    push(-3, got, lat, rl);
    push(0, got, lat, rl);
    checks++; if (got !== -16'sd5) begin errors++; $display("FAIL shift_floor: got %0d expected -5", got); end

    do_reset();
    cf = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    load(1, 1, 0, cf);
    push(32767, got, lat, rl);
    checks++; if (got !== 16'sd32767) begin errors++; $display("FAIL wrap_warmup: got %0d expected 32767", got); end
    push(1, got, lat, rl);
    checks++; if (got !== -16'sd32768) begin errors++; $display("FAIL wrap_sample: got %0d expected -32768", got); end
  endtask

  task automatic test_back_to_back_frame();
    int cf[12];
    int vals[8] = '{1, -2, 300, -4000, 5, 32767, -32768, 77};
    logic signed [15:0] got;
    int lat, rl;
    do_reset();
    cf = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    load(0, 1, 0, cf);
    for (int i = 0; i < 8; i++) begin
      push(vals[i], got, lat, rl);
      checks++; if (got !== 16'(vals[i]) || lat !== 1) begin errors++; $display("FAIL m0_passthru[%0d]: got %0d lat %0d expected %0d lat 1", i, got, lat, vals[i]); end
      if (i < 7) begin
        checks++; if (o8_done !== 1'b0) begin errors++; $display("FAIL early_framedone[%0d]: got %b expected 0", i, o8_done); end
      end
    end
    checks++; if (o8_valid !== 1'b1 || o8_done !== 1'b1) begin errors++; $display("FAIL framedone_pulse: valid %b done %b expected 1 1", o8_valid, o8_done); end
    checks++; if (o8_sample !== 16'sd77) begin errors++; $display("FAIL frame_last_sample: got %0d expected 77", o8_sample); end
    checks++; if (oFrameDone !== 1'b0) begin errors++; $display("FAIL framedone_4096: got %b expected 0", oFrameDone); end
    checks++; if (o8_ready !== 1'b0) begin errors++; $display("FAIL frame_end_ready: got %b expected 0", o8_ready); end
    iValid = 1'b1; iResidual = 16'sd9;
    step();
    iValid = 1'b0;
    checks++; if (o8_ready !== 1'b0 || o8_valid !== 1'b0 || o8_done !== 1'b0) begin errors++; $display("FAIL frame_idle: ready %b valid %b done %b expected 0 0 0", o8_ready, o8_valid, o8_done); end
  endtask

  task automatic test_order12_reset_enable();
    int cf[12];
    logic signed [15:0] got;
    int lat, rl;
    do_reset();
    cf = '{1, -1, 1, -1, 1, -1, 1, -1, 1, -1, 1, -1};
    load(12, 12, 1, cf);
    for (int i = 1; i <= 12; i++) begin
      push(i, got, lat, rl);
      checks++; if (got !== 16'(i) || lat !== 1) begin errors++; $display("FAIL m12_warmup[%0d]: got %0d lat %0d expected %0d lat 1", i, got, lat, i); end
    end
    // Accept a residual, then reset during MAC cycle 5.
    iValid = 1'b1; iResidual = 16'sd10;
    step();
    iValid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    iReset = 1'b1;
    step();
    checks++; if (oValid !== 1'b0 || oReady !== 1'b0 || oSample !== 16'sd0) begin errors++; $display("FAIL midmac_reset: valid %b ready %b sample %0d expected 0 0 0", oValid, oReady, oSample); end
    iReset = 1'b0;

    // Reload with iM=15, which must clamp to order 12.
    load(15, 12, 1, cf);
    for (int i = 1; i <= 12; i++) push(i, got, lat, rl);
    checks++; if (got !== 16'sd12) begin errors++; $display("FAIL reload_warmup: got %0d expected 12", got); end
    checks++; if (oReady !== 1'b1) begin errors++; $display("FAIL reload_ready: got %b expected 1", oReady); end

    // Residual 10 with iEnable low for 3 cycles mid-MAC: 13 + 3 cycles.
    iValid = 1'b1; iResidual = 16'sd10;
    step();
    iValid = 1'b0;
    lat = 1;
    for (int k = 0; k < 3; k++) begin step(); lat++; end
    iEnable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++; if (oValid !== 1'b0 || oReady !== 1'b0) begin errors++; $display("FAIL enable_low_gate[%0d]: valid %b ready %b expected 0 0", k, oValid, oReady); end
      step();
      lat++;
    end
    iEnable = 1'b1;
    while (!oValid && lat < 60) begin step(); lat++; end
    checks++; if (oValid !== 1'b1 || oSample !== 16'sd13) begin errors++; $display("FAIL m12_sample: valid %b got %0d expected 13", oValid, oSample); end
    checks++; if (lat !== 16) begin errors++; $display("FAIL m12_stretched_latency: got %0d expected 16", lat); end

    push(-20, got, lat, rl);
    checks++; if (got !== -16'sd17) begin errors++; $display("FAIL m12_sample2: got %0d expected -17", got); end
    checks++; if (lat !== 13) begin errors++; $display("FAIL m12_latency: got %0d expected 13", lat); end
  endtask

  initial begin
    test_reset();
    test_order1();
    test_order2();
    test_shift_and_wrap();
    test_back_to_back_frame();
    test_order12_reset_enable();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
